// File: rtl/time_disp_pkg.sv
// Shared types, field positions, limits and helpers for the time display decoder.
package time_disp_pkg;

  typedef enum logic [3:0] {
    D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, DASH, BLANK
  } digit_t;

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, COMMIT
  } state_t;

  localparam int HR_MSB  = 26;
  localparam int HR_LSB  = 22;
  localparam int MIN_MSB = 21;
  localparam int MIN_LSB = 16;
  localparam int SEC_MSB = 15;
  localparam int SEC_LSB = 10;
  localparam int MS_MSB  = 9;
  localparam int MS_LSB  = 0;

  localparam logic [4:0] HR_MAX   = 5'd11;
  localparam logic [5:0] MS_MAX   = 6'd59;
  localparam logic [9:0] COLON_MS = 10'd500;
  localparam logic [5:0] HR_NOON  = 6'd12;
  localparam int         DD_ITERS = 6;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input digit_t d);
    logic [6:0] s;
    case (d)
      D0:      s = 7'b1000000;
      D1:      s = 7'b1111001;
      D2:      s = 7'b0100100;
      D3:      s = 7'b0110000;
      D4:      s = 7'b0011001;
      D5:      s = 7'b0010010;
      D6:      s = 7'b0000010;
      D7:      s = 7'b1111000;
      D8:      s = 7'b0000000;
      D9:      s = 7'b0010000;
      DASH:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {bcd_tens, bcd_ones, bin[5:0]}.
  function automatic logic [13:0] dd_step(input logic [13:0] v);
    logic [13:0] a;
    a = v;
    if (a[9:6] >= 4'd5)   a[9:6]   = a[9:6] + 4'd3;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    return {a[12:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit 7-segment scanner: rotates the active digit and registers
// an_n, seg_n and dp_n together so they always change on the same edge.
module seg7_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic       kh_clk,
  input  logic       reset,
  input  digit_t     digits [4],
  input  logic       colon_on,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt_reg;
  logic [SW-1:0] scan_cnt_next;
  logic [1:0]    idx_reg;
  logic [1:0]    idx_next;
  logic [3:0]    an_next;

  always_comb begin
    scan_cnt_next = scan_cnt_reg + 1'b1;
    idx_next      = idx_reg;
    if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
      scan_cnt_next = '0;
      idx_next      = idx_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = (idx_next != 2'(gi));
    end
  endgenerate

  // Outputs are registered from the upcoming index so they stay aligned with idx_reg.
  always_ff @(posedge kh_clk) begin
    if (reset) begin
      scan_cnt_reg <= '0;
      idx_reg      <= 2'd0;
      an_n         <= 4'b1110;
      seg_n        <= 7'h7F;
      dp_n         <= 1'b1;
    end else begin
      scan_cnt_reg <= scan_cnt_next;
      idx_reg      <= idx_next;
      an_n         <= an_next;
      seg_n        <= seg_decode(digits[idx_next]);
      dp_n         <= !((idx_next == 2'd2) && colon_on);
    end
  end

endmodule

// File: rtl/time_disp_decoder.sv
// Snapshots the packed time bus, converts two fields to BCD and drives the display.
// Optional build macro LEAD_BLANK_EN blanks a leading zero in the upper tens digit.
module time_disp_decoder
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int SNAP_DIV = 10
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic [26:0] disp_time,
  input  logic        mode,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        busy,
  output logic        err
);

  localparam int SNW = $clog2(SNAP_DIV);

`ifdef LEAD_BLANK_EN
  localparam bit LEAD_BLANK = 1'b1;
`else
  localparam bit LEAD_BLANK = 1'b0;
`endif

  logic [SNW-1:0] snap_cnt_reg;
  logic           snap_tick;

  state_t      state_reg;
  logic [2:0]  iter_reg;
  logic [5:0]  up_bin_reg, lo_bin_reg;
  logic [7:0]  up_bcd_reg, lo_bcd_reg;
  logic        up_bad_reg, lo_bad_reg;
  logic [9:0]  ms_reg;
  logic        colon_on_reg;
  logic        busy_reg;
  logic        err_reg;
  digit_t      digit_reg [4];

  logic [4:0]  hr_f;
  logic [5:0]  min_f, sec_f;
  logic [5:0]  up_load, lo_load;
  logic        up_bad_load, lo_bad_load;
  digit_t      commit_digit [4];

  assign snap_tick = (snap_cnt_reg == SNW'(SNAP_DIV - 1));

  always_ff @(posedge kh_clk) begin
    if (reset || snap_tick) snap_cnt_reg <= '0;
    else                    snap_cnt_reg <= snap_cnt_reg + 1'b1;
  end

  // Field selection and range checks on the live bus, captured in LOAD.
  always_comb begin
    hr_f  = disp_time[HR_MSB:HR_LSB];
    min_f = disp_time[MIN_MSB:MIN_LSB];
    sec_f = disp_time[SEC_MSB:SEC_LSB];
    if (!mode) begin
      up_load     = (hr_f == 5'd0) ? HR_NOON : {1'b0, hr_f};
      up_bad_load = (hr_f > HR_MAX);
      lo_load     = min_f;
      lo_bad_load = (min_f > MS_MAX);
    end else begin
      up_load     = min_f;
      up_bad_load = (min_f > MS_MAX);
      lo_load     = sec_f;
      lo_bad_load = (sec_f > MS_MAX);
    end
  end

  always_comb begin
    commit_digit[3] = digit_t'(up_bcd_reg[7:4]);
    commit_digit[2] = digit_t'(up_bcd_reg[3:0]);
    commit_digit[1] = digit_t'(lo_bcd_reg[7:4]);
    commit_digit[0] = digit_t'(lo_bcd_reg[3:0]);
    if (LEAD_BLANK && (up_bcd_reg[7:4] == 4'd0)) commit_digit[3] = BLANK;
    if (up_bad_reg) begin
      commit_digit[3] = DASH;
      commit_digit[2] = DASH;
    end
    if (lo_bad_reg) begin
      commit_digit[1] = DASH;
      commit_digit[0] = DASH;
    end
  end

  always_ff @(posedge kh_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      iter_reg     <= 3'd0;
      up_bin_reg   <= '0;
      lo_bin_reg   <= '0;
      up_bcd_reg   <= '0;
      lo_bcd_reg   <= '0;
      up_bad_reg   <= 1'b0;
      lo_bad_reg   <= 1'b0;
      ms_reg       <= '0;
      colon_on_reg <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= BLANK;
    end else begin
      case (state_reg)
        IDLE: begin
          // Ticks landing in any other state are simply ignored.
          if (snap_tick) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          up_bin_reg <= up_load;
          lo_bin_reg <= lo_load;
          up_bad_reg <= up_bad_load;
          lo_bad_reg <= lo_bad_load;
          ms_reg     <= disp_time[MS_MSB:MS_LSB];
          up_bcd_reg <= '0;
          lo_bcd_reg <= '0;
          iter_reg   <= 3'd0;
          state_reg  <= SHIFT;
        end
        SHIFT: begin
          {up_bcd_reg, up_bin_reg} <= dd_step({up_bcd_reg, up_bin_reg});
          {lo_bcd_reg, lo_bin_reg} <= dd_step({lo_bcd_reg, lo_bin_reg});
          iter_reg <= iter_reg + 3'd1;
          if (iter_reg == 3'(DD_ITERS - 1)) state_reg <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) digit_reg[i] <= commit_digit[i];
          err_reg      <= up_bad_reg | lo_bad_reg;
          colon_on_reg <= (ms_reg < COLON_MS);
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .kh_clk  (kh_clk),
    .reset   (reset),
    .digits  (digit_reg),
    .colon_on(colon_on_reg),
    .an_n    (an_n),
    .seg_n   (seg_n),
    .dp_n    (dp_n)
  );

  assign busy = busy_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_time_disp_decoder.sv
// Directed bench for time_disp_decoder: reset state, conversions in both modes,
// range flags, colon threshold, mid-conversion bus changes and mid-conversion reset.
module tb_time_disp_decoder;

  logic        kh_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [26:0] disp_time;
  logic        mode;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        busy;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef LEAD_BLANK_EN
  localparam logic [6:0] SLZ = SB;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  time_disp_decoder dut (
    .kh_clk   (kh_clk),
    .reset    (reset),
    .disp_time(disp_time),
    .mode     (mode),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .busy     (busy),
    .err      (err)
  );

  always #5 kh_clk = ~kh_clk;

  function automatic logic [26:0] pack(input int hr, input int mn, input int sc, input int ms);
    return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic val, input string tag);
    for (int i = 0; i < 40 && busy !== val; i++) @(negedge kh_clk);
    chk(tag, 32'(busy), 32'(val));
  endtask

  // Waits for a conversion that starts after this call; ends on the negedge after COMMIT.
  task automatic run_conv(input string tag);
    int w;
    if (busy === 1'b1) wait_busy(1'b0, {tag, " idle"});
    wait_busy(1'b1, {tag, " start"});
    w = 0;
    while (busy === 1'b1 && w < 20) begin
      w++;
      @(negedge kh_clk);
    end
    chk({tag, " busy_len"}, 32'(w), 32'd8);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0, input logic colon);
    logic [6:0] e [4];
    int idx;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      @(negedge kh_clk);
      case (an_n)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      chk({tag, " an_onehot"}, 32'($countones(~an_n)), 32'd1);
      if (idx >= 0) begin
        chk($sformatf("%s seg[%0d]", tag, idx), 32'(seg_n), 32'(e[idx]));
        chk($sformatf("%s dp[%0d]", tag, idx), 32'(dp_n),
            ((idx == 2) && colon) ? 32'd0 : 32'd1);
      end
      $display("%s: an_n=%b seg_n=%b dp_n=%b", tag, an_n, seg_n, dp_n);
    end
  endtask

  initial begin
    logic [3:0] ea;
    mode      = 1'b0;
    disp_time = pack(0, 7, 42, 250);

    repeat (3) @(negedge kh_clk);
    chk("rst an_n", 32'(an_n), 32'h0E);
    chk("rst seg_n", 32'(seg_n), 32'h7F);
    chk("rst dp_n", 32'(dp_n), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 9; k++) begin
      @(negedge kh_clk);
      ea = ~(4'b0001 << (k % 4));
      chk($sformatf("idle%0d an_n", k), 32'(an_n), 32'(ea));
      chk($sformatf("idle%0d seg_n", k), 32'(seg_n), 32'h7F);
      chk($sformatf("idle%0d dp_n", k), 32'(dp_n), 32'd1);
      chk($sformatf("idle%0d busy", k), 32'(busy), 32'd0);
      chk($sformatf("idle%0d err", k), 32'(err), 32'd0);
      $display("idle cycle %0d: an_n=%b seg_n=%b busy=%b", k, an_n, seg_n, busy);
    end

    run_conv("h0m07");
    chk("h0m07 err", 32'(err), 32'd0);
    check_display("h0m07", S1, S2, S0, S7, 1'b1);

    mode = 1'b1;
    run_conv("m07s42");
    check_display("m07s42", SLZ, S7, S4, S2, 1'b1);

    disp_time = pack(0, 7, 42, 600);
    run_conv("ms600");
    check_display("ms600", SLZ, S7, S4, S2, 1'b0);

    mode = 1'b0;
    disp_time = pack(3, 63, 0, 499);
    run_conv("min63");
    chk("min63 err", 32'(err), 32'd1);
    check_display("min63", SLZ, S3, SD, SD, 1'b1);

    disp_time = pack(11, 59, 0, 500);
    run_conv("h11m59");
    chk("h11m59 err", 32'(err), 32'd0);
    check_display("h11m59", S1, S1, S5, S9, 1'b0);

    disp_time = pack(12, 30, 0, 0);
    run_conv("hr12");
    chk("hr12 err", 32'(err), 32'd1);
    check_display("hr12", SD, SD, S3, S0, 1'b1);

    mode = 1'b1;
    disp_time = pack(1, 5, 60, 0);
    run_conv("sec60");
    chk("sec60 err", 32'(err), 32'd1);
    check_display("sec60", SLZ, S5, SD, SD, 1'b1);

    // Reset lands in the middle of SHIFT.
    mode = 1'b0;
    disp_time = pack(9, 5, 0, 0);
    if (busy === 1'b1) wait_busy(1'b0, "midrst idle");
    wait_busy(1'b1, "midrst start");
    repeat (3) @(negedge kh_clk);
    reset = 1'b1;
    @(negedge kh_clk);
    chk("midrst an_n", 32'(an_n), 32'h0E);
    chk("midrst seg_n", 32'(seg_n), 32'h7F);
    chk("midrst dp_n", 32'(dp_n), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    $display("midrst: an_n=%b seg_n=%b busy=%b err=%b", an_n, seg_n, busy, err);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge kh_clk);
      chk($sformatf("postrst%0d seg_n", k), 32'(seg_n), 32'h7F);
      chk($sformatf("postrst%0d dp_n", k), 32'(dp_n), 32'd1);
    end

    run_conv("h9m05");
    chk("h9m05 err", 32'(err), 32'd0);
    check_display("h9m05", SLZ, S9, S0, S5, 1'b1);

    // Bus scrambled every cycle after LOAD has captured it.
    disp_time = pack(4, 25, 0, 100);
    if (busy === 1'b1) wait_busy(1'b0, "scramble idle");
    wait_busy(1'b1, "scramble start");
    @(negedge kh_clk);
    for (int w = 0; w < 20 && busy === 1'b1; w++) begin
      disp_time = 27'($urandom);
      mode      = 1'($urandom);
      @(negedge kh_clk);
    end
    chk("scramble busy", 32'(busy), 32'd0);
    chk("scramble err", 32'(err), 32'd0);
    check_display("scramble", SLZ, S4, S2, S5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
